pc_fetch: RTL and testbench

//  Front-end fetch stage: PC register plus instruction-memory request/response FSM and a 1-entry output buffer to ID.

---
 rtl/pc_fetch_pkg.sv | 21 ++
 rtl/pc_fetch_if.sv | 27 ++
 rtl/pc_fetch_buf.sv | 52 +++++
 rtl/pc_fetch.sv | 125 ++++++++++++
 tb/tb_pc_fetch.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared widths, NOP encoding and fetch FSM states for the pc_fetch slice.
// PC_FETCH_MISALIGN_CHK_EN adds the HALT state used after a misaligned redirect.
package pc_fetch_pkg;

    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned INST_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [INST_WIDTH-1:0] NOP_ENC = 32'h0000_0013;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StWait,
        StDrop
`ifdef PC_FETCH_MISALIGN_CHK_EN
        , StHalt
`endif
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bundle; master is the fetch stage, slave the memory.
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_buf.sv
// One-entry valid/ready output register between fetch and decode.
// A fill always wins over a clear or a consume in the same cycle.
module pc_fetch_buf
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_ENC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_i,
    input  logic [PC_WIDTH-1:0]   fill_pc_i,
    input  logic [INST_WIDTH-1:0] fill_inst_i,
    input  logic                  fill_exc_i,
    input  logic                  clear_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  exc_o
);

    logic                  r_valid;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_exc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_inst  <= NOP_INST;
            r_exc   <= 1'b0;
        end else if (fill_i) begin
            r_valid <= 1'b1;
            r_pc    <= fill_pc_i;
            r_inst  <= fill_inst_i;
            r_exc   <= fill_exc_i;
        end else if (clear_i || (r_valid && ready_i)) begin
            // Empty buffer always presents a NOP so ID never sees stale data.
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_exc   <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign pc_o    = r_pc;
    assign inst_o  = r_inst;
    assign exc_o   = r_exc;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC register, single-outstanding imem request FSM and output buffer to ID.
// Define PC_FETCH_MISALIGN_CHK_EN to tag misaligned redirects with if_exc_o and halt fetch.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_ENC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [PC_WIDTH-1:0]   flush_pc_i,
    pc_fetch_if.master            imem,
    input  logic                  id_ready_i,
    output logic                  if_valid_o,
    output logic [PC_WIDTH-1:0]   if_pc_o,
    output logic [INST_WIDTH-1:0] if_inst_o,
    output logic                  if_exc_o
);

    fetch_state_e          r_state;
    logic [PC_WIDTH-1:0]   r_pc;

    logic                  w_valid;
    logic                  w_req;
    logic                  w_stale;
    logic                  w_rsp_fill;
    logic                  w_exc_fill;
    logic                  w_fill;
    logic [PC_WIDTH-1:0]   w_flush_pc;
    logic [PC_WIDTH-1:0]   w_buf_pc;
    logic [INST_WIDTH-1:0] w_buf_inst;

    // A request is only made when the buffer is free or draining this cycle.
    assign w_req = (r_state == StFetch) && !flush_i && (!w_valid || id_ready_i);

    // A response is still owed after this cycle: a flush now makes it stale.
    assign w_stale = ((r_state == StWait) || (r_state == StDrop)) && !imem.imem_rvalid;

    assign w_rsp_fill = (r_state == StWait) && imem.imem_rvalid && !flush_i;

`ifdef PC_FETCH_MISALIGN_CHK_EN
    logic r_exc_pend;
    logic w_misalign;

    assign w_misalign = flush_i && (flush_pc_i[1:0] != 2'b00);
    assign w_flush_pc = flush_pc_i;
    assign w_exc_fill = (w_misalign && !w_stale) ||
                        (!flush_i && r_exc_pend && (r_state == StDrop) && imem.imem_rvalid);
    assign w_buf_pc   = w_exc_fill ? (flush_i ? flush_pc_i : r_pc) : r_pc - PC_WIDTH'(4);
`else
    assign w_flush_pc = flush_pc_i & ~PC_WIDTH'(3);
    assign w_exc_fill = 1'b0;
    assign w_buf_pc   = r_pc - PC_WIDTH'(4);
`endif

    assign w_fill     = w_rsp_fill || w_exc_fill;
    assign w_buf_inst = w_exc_fill ? NOP_INST : imem.imem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StBoot;
            r_pc       <= RESET_PC;
`ifdef PC_FETCH_MISALIGN_CHK_EN
            r_exc_pend <= 1'b0;
`endif
        end else if (flush_i) begin
            r_pc    <= w_flush_pc;
            r_state <= w_stale ? StDrop : StFetch;
`ifdef PC_FETCH_MISALIGN_CHK_EN
            r_exc_pend <= w_misalign && w_stale;
            if (w_misalign && !w_stale) r_state <= StHalt;
`endif
        end else begin
            case (r_state)
                StBoot:  r_state <= StFetch;
                StFetch: begin
                    if (w_req && imem.imem_gnt) begin
                        r_pc    <= r_pc + PC_WIDTH'(4);
                        r_state <= StWait;
                    end
                end
                StWait:  if (imem.imem_rvalid) r_state <= StFetch;
                StDrop: begin
                    if (imem.imem_rvalid) begin
`ifdef PC_FETCH_MISALIGN_CHK_EN
                        r_state    <= r_exc_pend ? StHalt : StFetch;
                        r_exc_pend <= 1'b0;
`else
                        r_state <= StFetch;
`endif
                    end
                end
`ifdef PC_FETCH_MISALIGN_CHK_EN
                StHalt:  r_state <= StHalt;
`endif
                default: r_state <= StFetch;
            endcase
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    pc_fetch_buf #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fill_i      (w_fill),
        .fill_pc_i   (w_buf_pc),
        .fill_inst_i (w_buf_inst),
        .fill_exc_i  (w_exc_fill),
        .clear_i     (flush_i),
        .ready_i     (id_ready_i),
        .valid_o     (w_valid),
        .pc_o        (if_pc_o),
        .inst_o      (if_inst_o),
        .exc_o       (if_exc_o)
    );

    assign if_valid_o = w_valid;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch (default build): directed scenarios with literal
// expectations, then randomized imem/ID/flush traffic checked against a transaction model.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        id_ready_i = 1'b0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_exc_o;

    pc_fetch_if u_if ();

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .imem       (u_if),
        .id_ready_i (id_ready_i),
        .if_valid_o (if_valid_o),
        .if_pc_o    (if_pc_o),
        .if_inst_o  (if_inst_o),
        .if_exc_o   (if_exc_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: next fetch address, one optional outstanding request, the ID-side entry.
    bit          m_known = 0;
    bit          m_boot  = 1;
    bit          m_outst = 0;
    bit          m_stale = 0;
    bit          m_valid = 0;
    logic [31:0] m_pc     = '0;
    logic [31:0] m_req_pc = '0;
    logic [31:0] m_bpc    = '0;
    logic [31:0] m_binst  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req();
        return !m_boot && !m_outst && !flush_i && (!m_valid || id_ready_i);
    endfunction

    task automatic drive(input bit rst, input bit fl, input logic [31:0] fpc, input bit g,
                         input bit rv, input logic [31:0] rd, input bit rdy);
        @(negedge clk);
        rst_n              = rst;
        flush_i            = fl;
        flush_pc_i         = fpc;
        u_if.imem_gnt      = g;
        u_if.imem_rvalid   = rv;
        u_if.imem_rdata    = rd;
        id_ready_i         = rdy;
        #1;
        if (m_known) begin
            check("model_req", 32'(u_if.imem_req), 32'(m_req()));
            check("model_addr", u_if.imem_addr, m_pc);
            check("model_valid", 32'(if_valid_o), 32'(m_valid));
            check("model_exc", 32'(if_exc_o), 32'd0);
            if (m_valid) begin
                check("model_if_pc", if_pc_o, m_bpc);
                check("model_if_inst", if_inst_o, m_binst);
            end else begin
                check("model_nop", if_inst_o, NOP);
            end
        end
    endtask

    task automatic tick();
        bit req;
        @(posedge clk);
        req = m_req();
        if (!rst_n) begin
            m_known = 1; m_boot = 1; m_outst = 0; m_stale = 0; m_valid = 0; m_pc = '0;
        end else if (flush_i) begin
            m_pc    = flush_pc_i & ~32'h3;
            m_valid = 0;
            m_boot  = 0;
            if (m_outst) begin
                if (u_if.imem_rvalid) m_outst = 0;
                else                  m_stale = 1;
            end
        end else begin
            if (m_valid && id_ready_i) m_valid = 0;
            if (m_outst && u_if.imem_rvalid) begin
                if (!m_stale) begin
                    m_valid = 1;
                    m_bpc   = m_req_pc;
                    m_binst = u_if.imem_rdata;
                end
                m_outst = 0;
                m_stale = 0;
            end
            if (req && u_if.imem_gnt) begin
                m_outst  = 1;
                m_stale  = 0;
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
            m_boot = 0;
        end
    endtask

    initial begin
        u_if.imem_gnt    = 1'b0;
        u_if.imem_rvalid = 1'b0;
        u_if.imem_rdata  = '0;

        // Reset
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_inst", if_inst_o, NOP);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_req", 32'(u_if.imem_req), 32'd0);
        tick();

        // Boot cycle, then first request at 0x0
        drive(1, 0, 0, 0, 0, 0, 1); check("boot_req", 32'(u_if.imem_req), 32'd0); tick();
        drive(1, 0, 0, 1, 0, 0, 1);
        check("first_req", 32'(u_if.imem_req), 32'd1);
        check("first_addr", u_if.imem_addr, 32'h0);
        tick();
        drive(1, 0, 0, 0, 1, 32'hA000_0001, 1);
        check("wait_req", 32'(u_if.imem_req), 32'd0);
        tick();
        drive(1, 0, 0, 1, 0, 0, 1);
        check("out0_valid", 32'(if_valid_o), 32'd1);
        check("out0_pc", if_pc_o, 32'h0);
        check("out0_inst", if_inst_o, 32'hA000_0001);
        check("second_addr", u_if.imem_addr, 32'h4);
        tick();
        drive(1, 0, 0, 0, 1, 32'hA000_0002, 1);
        check("pulse_gap", 32'(if_valid_o), 32'd0);
        tick();

        // ID stall with full buffer: no request, outputs hold
        drive(1, 0, 0, 0, 0, 0, 0);
        check("out1_pc", if_pc_o, 32'h4);
        check("out1_inst", if_inst_o, 32'hA000_0002);
        check("stall_req", 32'(u_if.imem_req), 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        check("stall_hold", if_pc_o, 32'h4);
        check("stall_req2", 32'(u_if.imem_req), 32'd0);
        tick();

        // Ready returns: request same cycle; gnt withheld for 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1);
            check("nogt_req", 32'(u_if.imem_req), 32'd1);
            check("nogt_addr", u_if.imem_addr, 32'h8);
            tick();
        end
        drive(1, 0, 0, 1, 0, 0, 1); check("gnt_addr", u_if.imem_addr, 32'h8); tick();

        // Flush in WAIT; stale 0xDEAD must be dropped
        drive(1, 1, 32'h100, 0, 0, 0, 1); check("flush_req", 32'(u_if.imem_req), 32'd0); tick();
        drive(1, 0, 0, 0, 1, 32'h0000_DEAD, 1); check("drop_req", 32'(u_if.imem_req), 32'd0); tick();
        drive(1, 0, 0, 1, 0, 0, 1);
        check("drop_valid", 32'(if_valid_o), 32'd0);
        check("drop_inst", if_inst_o, NOP);
        check("redir_addr", u_if.imem_addr, 32'h100);
        check("redir_req", 32'(u_if.imem_req), 32'd1);
        tick();

        // Flush together with rvalid: data dropped, fetch resumes at 0x200
        drive(1, 1, 32'h200, 0, 1, 32'h0000_BEEF, 1); tick();
        drive(1, 0, 0, 0, 0, 0, 1);
        check("fr_req", 32'(u_if.imem_req), 32'd1);
        check("fr_addr", u_if.imem_addr, 32'h200);
        check("fr_valid", 32'(if_valid_o), 32'd0);
        tick();

        // Misaligned target is word-aligned in this build
        drive(1, 1, 32'h302, 1, 0, 0, 1); tick();
        drive(1, 0, 0, 1, 0, 0, 1); check("align_addr", u_if.imem_addr, 32'h300); tick();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          rst, fl, g, rv, rdy;
            logic [31:0] fpc;
            rst = ($urandom_range(0, 499) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            fpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            g   = 1'($urandom_range(0, 1));
            rv  = m_outst ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            drive(rst, fl, fpc, g, rv, $urandom, rdy);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
